// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg
//   Shared constants and types for the change dispenser:
//   main-FSM state codes that trigger a payout, the dispenser state
//   encoding, default coin denominations and the ack timeout.
package change_dispenser_pkg;

  localparam int AMT_W = 5;   // money / coin-count width

  // Main FSM states that request a payout
  localparam logic [2:0] MAIN_REFUND = 3'd2;
  localparam logic [2:0] MAIN_CHANGE = 3'd3;

  // Default denominations, largest first; the smallest must be 1
  localparam int DEF_DEN0 = 10;
  localparam int DEF_DEN1 = 5;
  localparam int DEF_DEN2 = 2;
  localparam int DEF_DEN3 = 1;

  // Cycles allowed for coinAck per coin (8-bit counter)
  localparam int DEF_ACK_TIMEOUT = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_OFFER = 3'd1,
    ST_DONE  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if
//   Bundle between the main FSM / coin actuator and the dispenser.
//   master : main FSM + actuator side (drives mainState, moneyToGive, coinAck)
//   slave  : dispenser side (drives coin offer and status outputs)
interface change_dispenser_if;
  import change_dispenser_pkg::*;

  logic [2:0]       mainState;
  logic [AMT_W-1:0] moneyToGive;
  logic             coinAck;
  logic             coinValid;
  logic [AMT_W-1:0] coinValue;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] coinsOut;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    output mainState, moneyToGive, coinAck,
    input  coinValid, coinValue, remaining, coinsOut, busy, done, error
  );

  modport slave (
    input  mainState, moneyToGive, coinAck,
    output coinValid, coinValue, remaining, coinsOut, busy, done, error
  );

endinterface

// File: rtl/change_dispenser_denom_select.sv
// change_dispenser_denom_select
//   Combinational greedy picker: returns the largest denomination that
//   does not exceed the amount still owed, or 0 when nothing fits.
//   i_remaining : amount still owed
//   o_coin      : denomination to offer next
module change_dispenser_denom_select
  import change_dispenser_pkg::*;
#(
  parameter int DEN0 = DEF_DEN0,
  parameter int DEN1 = DEF_DEN1,
  parameter int DEN2 = DEF_DEN2,
  parameter int DEN3 = DEF_DEN3
) (
  input  logic [AMT_W-1:0] i_remaining,
  output logic [AMT_W-1:0] o_coin
);

  localparam logic [AMT_W-1:0] DENS [4] = '{
    AMT_W'(DEN0), AMT_W'(DEN1), AMT_W'(DEN2), AMT_W'(DEN3)
  };

  logic [3:0] w_fit;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fit
    assign w_fit[gi] = (i_remaining >= DENS[gi]);
  end

  // Scan smallest to largest so the largest fitting coin wins last
  always_comb begin
    o_coin = '0;
    for (int i = 3; i >= 0; i--) begin
      if (w_fit[i]) o_coin = DENS[i];
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser
//   Pays out an amount as a sequence of coins, largest first, with one
//   valid/ack handshake per coin. Refund and change payouts are identical.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave side of change_dispenser_if
//           in : mainState, moneyToGive, coinAck
//           out: coinValid, coinValue, remaining, coinsOut, busy, done, error
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int DEN0        = DEF_DEN0,
  parameter int DEN1        = DEF_DEN1,
  parameter int DEN2        = DEF_DEN2,
  parameter int DEN3        = DEF_DEN3,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  change_dispenser_if.slave   bus
);

  state_t           r_state;
  logic [AMT_W-1:0] r_remaining;
  logic [AMT_W-1:0] r_coins_out;
  logic [7:0]       r_ack_cnt;
  logic             r_coin_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_error;

  logic             w_active;
  logic [AMT_W-1:0] w_pick;
  logic [AMT_W-1:0] w_rem_after;
  logic [7:0]       w_cnt_inc;

  assign w_active    = (bus.mainState == MAIN_REFUND) ||
                       (bus.mainState == MAIN_CHANGE);
  assign w_rem_after = r_remaining - w_pick;
  assign w_cnt_inc   = r_ack_cnt + 8'd1;

  change_dispenser_denom_select #(
    .DEN0(DEN0), .DEN1(DEN1), .DEN2(DEN2), .DEN3(DEN3)
  ) u_denom_select (
    .i_remaining (r_remaining),
    .o_coin      (w_pick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_remaining  <= '0;
      r_coins_out  <= '0;
      r_ack_cnt    <= '0;
      r_coin_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_active) begin
            r_remaining <= bus.moneyToGive;
            r_coins_out <= '0;
            r_ack_cnt   <= '0;
            if (bus.moneyToGive == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state      <= ST_OFFER;
              r_coin_valid <= 1'b1;
              r_busy       <= 1'b1;
            end
          end
        end

        ST_OFFER: begin
          if (!w_active) begin
            // Abort wins over a coincident ack; totals keep last values
            r_state      <= ST_IDLE;
            r_coin_valid <= 1'b0;
            r_busy       <= 1'b0;
          end else if (bus.coinAck) begin
            r_remaining <= w_rem_after;
            r_coins_out <= r_coins_out + AMT_W'(1);
            r_ack_cnt   <= '0;
            if (w_rem_after == '0) begin
              r_state      <= ST_DONE;
              r_coin_valid <= 1'b0;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
            end
          end else begin
            r_ack_cnt <= w_cnt_inc;
            if (w_cnt_inc == 8'(ACK_TIMEOUT)) begin
              r_state      <= ST_ERROR;
              r_coin_valid <= 1'b0;
              r_busy       <= 1'b0;
              r_error      <= 1'b1;
            end
          end
        end

        // done was raised on entry; it drops here after one cycle
        ST_DONE: r_state <= ST_HOLD;

        // Block a second payout until the main FSM leaves refund/change
        ST_HOLD: begin
          if (!w_active) r_state <= ST_IDLE;
        end

        ST_ERROR: begin
          if (!w_active) begin
            r_state   <= ST_IDLE;
            r_error   <= 1'b0;
            r_ack_cnt <= '0;
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_coin_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_error      <= 1'b0;
        end
      endcase
    end
  end

  // Picker output is only presented while an offer is live
  assign bus.coinValue = r_coin_valid ? w_pick : '0;
  assign bus.coinValid = r_coin_valid;
  assign bus.remaining = r_remaining;
  assign bus.coinsOut  = r_coins_out;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.error     = r_error;

endmodule
